avmm_csr_bank: RTL and testbench

Avalon-MM agent (slave) register bank that terminates the configuration bus driven by the testbench/host master. It accepts single-beat reads and writes with byte enables, controls `waitrequest`, and returns read data through a fixed-latency `readdatavalid` pipeline. It exposes the register contents as a flat vector to the downstream AIB configuration logic.

---
 rtl/avmm_csr_pkg.sv | 34 +++
 rtl/avmm_rd_pipe.sv | 35 +++
 rtl/avmm_csr_bank.sv | 124 ++++++++++++
 tb/tb_avmm_csr_bank.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/avmm_csr_pkg.sv
// Shared types, constants and the byte-enable merge helper for the CSR bank.
package avmm_csr_pkg;

  localparam int          AVMM_ADDR_W = 17;
  localparam logic [31:0] DEFAULT_ID  = 32'hA1B0_0001;

  // Merge helper works on a wide container; callers size-cast in and out.
  localparam int MERGE_MAX_W  = 256;
  localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCEPT  = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ACCEPT  = ST_ACCEPT,
    RD_WAIT = ST_RD_WAIT
  } csr_state_e;

  function automatic logic [MERGE_MAX_W-1:0] be_merge(
    input logic [MERGE_MAX_W-1:0]  old_word,
    input logic [MERGE_MAX_W-1:0]  new_word,
    input logic [MERGE_MAX_BE-1:0] be
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_word;
    for (int b = 0; b < MERGE_MAX_BE; b++) begin
      if (be[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/avmm_rd_pipe.sv
// Fixed-latency read-return pipeline: valid/data shift register loaded at accept.
module avmm_rd_pipe #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] vld;
  logic [W-1:0]     dat [DEPTH];

  // Data stages only advance behind a valid, so the last stage holds after the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < DEPTH; k++) dat[k] <= '0;
    end else begin
      vld[0] <= in_valid;
      if (in_valid) dat[0] <= in_data;
      for (int k = 1; k < DEPTH; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1]) dat[k] <= dat[k-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/avmm_csr_bank.sv
// Avalon-MM agent register bank with byte enables and fixed-latency read return.
//   state      | meaning
//   IDLE       | waitrequest high, waiting for read or write
//   ACCEPT     | waitrequest low for one cycle; transfer completes here
//   RD_WAIT    | read in flight; last cycle carries readdatavalid
module avmm_csr_bank
  import avmm_csr_pkg::*;
#(
  parameter int                     AVMM_WIDTH = 32,
  parameter int                     BYTE_WIDTH = 4,
  parameter int                     NUM_REGS   = 16,
  parameter logic [AVMM_ADDR_W-1:0] BASE_ADDR  = 17'h0,
  parameter int                     RD_LATENCY = 2,
  parameter logic [AVMM_WIDTH-1:0]  ID_VALUE   = DEFAULT_ID
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [AVMM_ADDR_W-1:0]         address,
  input  logic                           read,
  input  logic                           write,
  input  logic [AVMM_WIDTH-1:0]          writedata,
  input  logic [BYTE_WIDTH-1:0]          byteenable,
  output logic [AVMM_WIDTH-1:0]          readdata,
  output logic                           readdatavalid,
  output logic                           waitrequest,
  output logic [NUM_REGS*AVMM_WIDTH-1:0] cfg_regs,
  output logic                           protocol_err
);

  localparam int                CNT_W    = 4;
  localparam logic [CNT_W-1:0]  LAT_INIT = CNT_W'(RD_LATENCY - 1);

  logic [1:0]                   state;
  logic [CNT_W-1:0]             lat_cnt;
  logic [AVMM_WIDTH-1:0]        regs [1:NUM_REGS-1];

  logic [AVMM_ADDR_W-1:0]       idx;
  logic [31:0]                  idx_w;
  logic                         in_range;
  logic [AVMM_WIDTH-1:0]        rd_word;
  logic [AVMM_WIDTH-1:0]        merged;
  logic                         rd_start;

  assign idx      = address - BASE_ADDR;
  assign idx_w    = 32'(idx);
  assign in_range = (address >= BASE_ADDR) && (idx_w < 32'(NUM_REGS));

  // Register 0 is the constant ID; out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    if (in_range) begin
      if (idx_w == 32'd0) rd_word = ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (idx_w == 32'(i)) rd_word = regs[i];
      end
    end
  end

  assign merged = AVMM_WIDTH'(be_merge(MERGE_MAX_W'(rd_word),
                                       MERGE_MAX_W'(writedata),
                                       MERGE_MAX_BE'(byteenable)));

  assign rd_start = (state == ST_ACCEPT) && read && !write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      waitrequest  <= 1'b1;
      lat_cnt      <= '0;
      protocol_err <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (read || write) begin
            state       <= ST_ACCEPT;
            waitrequest <= 1'b0;
          end
        end
        ST_ACCEPT: begin
          waitrequest <= 1'b1;
          state       <= ST_IDLE;
          if (write) begin
            for (int i = 1; i < NUM_REGS; i++) begin
              if (in_range && idx_w == 32'(i)) regs[i] <= merged;
            end
            // A concurrent read is dropped; the write wins.
            if (!in_range || read) protocol_err <= 1'b1;
          end else if (read) begin
            if (!in_range) protocol_err <= 1'b1;
            lat_cnt <= LAT_INIT;
            state   <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (lat_cnt == '0) state   <= ST_IDLE;
          else               lat_cnt <= lat_cnt - CNT_W'(1);
        end
        default: begin
          state       <= ST_IDLE;
          waitrequest <= 1'b1;
        end
      endcase
    end
  end

  avmm_rd_pipe #(
    .W     (AVMM_WIDTH),
    .DEPTH (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_start),
    .in_data   (rd_word),
    .out_valid (readdatavalid),
    .out_data  (readdata)
  );

  assign cfg_regs[0 +: AVMM_WIDTH] = ID_VALUE;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cfg
    assign cfg_regs[g*AVMM_WIDTH +: AVMM_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_avmm_csr_bank.sv
// Directed bench for avmm_csr_bank with a read-data scoreboard and register model.
module tb_avmm_csr_bank;

  localparam int          RD_LAT = 2;
  localparam logic [31:0] ID     = 32'hA1B0_0001;

  logic         clk = 1'b0;
  logic         rst;
  logic [16:0]  address;
  logic         read;
  logic         write;
  logic [31:0]  writedata;
  logic [3:0]   byteenable;
  logic [31:0]  readdata;
  logic         readdatavalid;
  logic         waitrequest;
  logic [511:0] cfg_regs;
  logic         protocol_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  logic [31:0] mdl [16];

  avmm_csr_bank #(
    .RD_LATENCY (RD_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .waitrequest   (waitrequest),
    .cfg_regs      (cfg_regs),
    .protocol_err  (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] model_cfg();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = mdl[i];
    return v;
  endfunction

  task automatic model_reset();
    mdl[0] = ID;
    for (int i = 1; i < 16; i++) mdl[i] = 32'h0;
  endtask

  // Scoreboard: every readdatavalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (readdatavalid) begin
      if (exp_q.size() == 0) chk("stray_readdatavalid", 512'(readdatavalid), 512'(0));
      else                   chk("readdata", 512'(readdata), 512'(exp_q.pop_front()));
    end
  end

  task automatic handshake(input logic rd, input logic wr, input logic [16:0] a,
                           input logic [31:0] d, input logic [3:0] be);
    int n;
    @(negedge clk);
    address = a; read = rd; write = wr; writedata = d; byteenable = be;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (waitrequest && n < 20);
    chk("accept_latency", 512'(n), 512'(1));
    @(negedge clk);
    read = 1'b0; write = 1'b0; byteenable = 4'h0;
  endtask

  task automatic do_write(input logic [16:0] a, input logic [31:0] d, input logic [3:0] be);
    if (a != 0 && a < 16) begin
      for (int b = 0; b < 4; b++) if (be[b]) mdl[a][b*8 +: 8] = d[b*8 +: 8];
    end
    handshake(1'b0, 1'b1, a, d, be);
    chk("cfg_after_write", cfg_regs, model_cfg());
  endtask

  task automatic do_read(input logic [16:0] a, input logic [31:0] exp);
    int k;
    exp_q.push_back(exp);
    handshake(1'b1, 1'b0, a, 32'h0, 4'h0);
    k = 0;
    while (!readdatavalid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rd_latency", 512'(k), 512'(RD_LAT - 1));
    @(negedge clk);
    chk("rdv_one_cycle", 512'(readdatavalid), 512'(0));
    chk("readdata_hold", 512'(readdata), 512'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0; byteenable = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    chk("rst_waitrequest", 512'(waitrequest), 512'(1));
    chk("rst_readdatavalid", 512'(readdatavalid), 512'(0));
    chk("rst_readdata", 512'(readdata), 512'(0));
    chk("rst_protocol_err", 512'(protocol_err), 512'(0));
    chk("rst_cfg_regs", cfg_regs, model_cfg());
    do_read(17'd0, ID);

    do_write(17'd3, 32'h1234_5678, 4'hF);
    chk("cfg_reg3_full", 512'(cfg_regs[127:96]), 512'(32'h1234_5678));
    do_read(17'd3, 32'h1234_5678);

    do_write(17'd3, 32'hAABB_CCDD, 4'b0101);
    chk("cfg_reg3_partial", 512'(cfg_regs[127:96]), 512'(32'h12BB_56DD));
    do_read(17'd3, 32'h12BB_56DD);

    do_write(17'd0, 32'hDEAD_BEEF, 4'hF);
    do_read(17'd0, ID);
    chk("reg0_write_no_err", 512'(protocol_err), 512'(0));

    do_write(17'd5, 32'hFFFF_FFFF, 4'h0);
    chk("be_zero_no_err", 512'(protocol_err), 512'(0));

    do_write(17'd7, 32'h5A00_0000, 4'b1000);
    do_write(17'd15, 32'h0F0F_0F0F, 4'hF);
    do_read(17'd15, 32'h0F0F_0F0F);

    do_write(17'd20, 32'hCAFE_F00D, 4'hF);
    chk("oor_write_err", 512'(protocol_err), 512'(1));
    do_read(17'd20, 32'h0);
    chk("oor_err_sticky", 512'(protocol_err), 512'(1));
    do_read(17'd7, 32'h5A00_0000);
    chk("err_persists", 512'(protocol_err), 512'(1));

    // Reset while a read sits in RD_WAIT: no return strobe may follow.
    handshake(1'b1, 1'b0, 17'd3, 32'h0, 4'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_mid_read_cfg", cfg_regs, model_cfg());
    chk("rst_mid_read_err", 512'(protocol_err), 512'(0));
    chk("rst_mid_read_wait", 512'(waitrequest), 512'(1));
    chk("rst_mid_read_rdv", 512'(readdatavalid), 512'(0));
    repeat (6) @(negedge clk);
    do_read(17'd3, 32'h0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 512'(exp_q.size()), 512'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
